// File: rtl/mem_access_ctrl.sv
// Access controller for the datapath dual-port RAM.
// Port A serves load/store requests; port B runs the pattern fill engine.
module mem_access_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_pattern,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_address_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_wren_a,
  input  logic [DATA_W-1:0] ram_q_a,
  output logic [ADDR_W-1:0] ram_address_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_wren_b
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_pat;
  logic [READ_LAT-1:0] r_vld;

  logic w_fill;
  logic w_hit;
  logic w_accept;
  logic w_load;
  logic w_len_nz;
  logic w_latch;

  assign w_fill   = (r_state == S_FILL);
  assign w_len_nz = (fill_len != '0);
  assign w_latch  = (r_state == S_IDLE) & fill_start & w_len_nz;

  // Stall port A when it targets the word port B writes this cycle
  assign w_hit    = w_fill & (req_addr == r_ptr);
  assign req_ready = ~reset & ~w_hit;
  assign w_accept = req_valid & req_ready;
  assign w_load   = w_accept & ~req_we;

  assign ram_address_a = req_addr;
  assign ram_data_a    = req_wdata;
  assign ram_wren_a    = w_accept & req_we;

  assign ram_address_b = r_ptr;
  assign ram_data_b    = r_pat;
  assign ram_wren_b    = w_fill & ~reset;

  assign fill_busy = w_fill;
  assign fill_done = (r_state == S_DONE);

  assign rsp_valid = r_vld[READ_LAT-1];
  assign rsp_rdata = rsp_valid ? ram_q_a : '0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (fill_start) begin
          w_next = w_len_nz ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        if (r_cnt == ADDR_W'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_pat   <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_ptr <= fill_base;
        r_cnt <= fill_len;
        r_pat <= fill_pattern;
      end else if (w_fill) begin
        r_ptr <= r_ptr + ADDR_W'(1);
        r_cnt <= r_cnt - ADDR_W'(1);
      end
    end
  end

  // Load tracker: one bit per cycle of RAM read latency
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_load;
      for (int i = 1; i < READ_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

endmodule
